// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic pipeline stage register with a valid/ready handshake,
//               synchronous flush and bubble-safe control outputs.
//               SKID=1 builds a 2-entry skid buffer with a registered in_ready.
//               SKID=0 builds a single entry with a combinational in_ready.
//               Optional feature macro: PIPE_STAGE_PERF_EN adds saturating
//               stall_cnt / bubble_cnt performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_PERF_EN
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
`else
  output logic [1:0]        occupancy
`endif
);

  // State encoding doubles as the entry count, so occupancy is the state.
  // SKID=0 only ever uses EMPTY and ONE (ONE acts as FULL).
  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_TWO   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_accept;
  logic              w_release;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;

  // Both handshakes are evaluated against the same edge.
  assign w_accept  = in_valid & in_ready;
  assign w_release = out_valid & out_ready;

  // State register; reset returns to EMPTY immediately, no clock needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output decode from the current state.
  always_comb begin
    out_valid = (r_state != c_EMPTY);
    occupancy = r_state;
  end

  // The main register always drives the downstream payload; control is
  // gated by valid so a bubble can never raise a write enable downstream.
  assign out_data = r_main_data;
  assign out_ctrl = r_main_ctrl & {CTRL_W{out_valid}};

  generate
    if (SKID != 0) begin : g_skid
      logic              r_in_ready;
      logic [DATA_W-1:0] r_skid_data;
      logic [CTRL_W-1:0] r_skid_ctrl;

      // Next-state: flush wins, then the EMPTY/ONE/TWO occupancy walk.
      always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
          w_state_nxt = c_EMPTY;
        end else begin
          case (r_state)
            c_EMPTY: begin
              if (w_accept) begin
                w_state_nxt = c_ONE;
              end
            end
            c_ONE: begin
              if (w_accept && !w_release) begin
                w_state_nxt = c_TWO;
              end else if (!w_accept && w_release) begin
                w_state_nxt = c_EMPTY;
              end
            end
            c_TWO: begin
              if (w_release) begin
                w_state_nxt = c_ONE;
              end
            end
            default: w_state_nxt = c_EMPTY;
          endcase
        end
      end

      // Ready is a flop so downstream back-pressure never ripples
      // combinationally to upstream; it drops only while both slots are full.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != c_TWO);
        end
      end

      assign in_ready = r_in_ready;

      // Payload movement: main takes new data when it is free or being
      // released, the skid slot catches data arriving while main is held.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_main_data <= '0;
          r_main_ctrl <= '0;
          r_skid_data <= '0;
          r_skid_ctrl <= '0;
        end else if (flush) begin
          // Main keeps its last payload (ctrl is masked by valid anyway);
          // the skid slot is wiped so nothing stale can resurface.
          r_skid_data <= '0;
          r_skid_ctrl <= '0;
        end else begin
          case (r_state)
            c_EMPTY: begin
              if (w_accept) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
              end
            end
            c_ONE: begin
              if (w_accept && w_release) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
              end else if (w_accept) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
              end
            end
            c_TWO: begin
              if (w_release) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
                r_skid_data <= '0;
                r_skid_ctrl <= '0;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end else begin : g_noskid
      // Single slot: can accept whenever the slot is empty or draining.
      assign in_ready = !out_valid | out_ready;

      // Next-state: flush wins, otherwise EMPTY/FULL toggling.
      always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
          w_state_nxt = c_EMPTY;
        end else begin
          case (r_state)
            c_EMPTY: begin
              if (w_accept) begin
                w_state_nxt = c_ONE;
              end
            end
            c_ONE: begin
              if (w_release && !w_accept) begin
                w_state_nxt = c_EMPTY;
              end
            end
            default: w_state_nxt = c_EMPTY;
          endcase
        end
      end

      // Load the slot on every accept; a flushed-cycle accept is dropped.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_main_data <= '0;
          r_main_ctrl <= '0;
        end else if (!flush && w_accept) begin
          r_main_data <= in_data;
          r_main_ctrl <= in_ctrl;
        end
      end
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_bubble_cnt;

  // Saturating stall/bubble counters; only reset clears them, not flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (!out_valid && (r_bubble_cnt != 16'hFFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. Drives a SKID=1 and a
//               SKID=0 instance from the same inputs and compares both against
//               a queue-based model of a bounded FIFO with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 8;
  typedef logic [CW+DW-1:0] ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DW-1:0] out_data1, out_data0;
  logic [CW-1:0] out_ctrl1, out_ctrl0;
  logic [1:0]    occ1, occ0;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]   stall1, bubble1, stall0, bubble0;
`endif

  int total = 0;
  int bad   = 0;

  ent_t q1[$];
  ent_t q0[$];
  ent_t last1, last0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1),
`ifdef PIPE_STAGE_PERF_EN
    .occupancy(occ1), .stall_cnt(stall1), .bubble_cnt(bubble1)
`else
    .occupancy(occ1)
`endif
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0),
`ifdef PIPE_STAGE_PERF_EN
    .occupancy(occ0), .stall_cnt(stall0), .bubble_cnt(bubble0)
`else
    .occupancy(occ0)
`endif
  );

  task automatic drive(input logic fl, input logic iv, input logic ordy,
                       input logic [DW-1:0] d, input logic [CW-1:0] c);
    flush = fl; in_valid = iv; out_ready = ordy; in_data = d; in_ctrl = c;
    #1;
  endtask

  // One clock edge; the model moves entries as a bounded FIFO would.
  task automatic tick();
    logic acc1, rel1, acc0, rel0;
    acc1 = in_valid && (q1.size() < 2);
    rel1 = (q1.size() > 0) && out_ready;
    acc0 = in_valid && ((q0.size() == 0) || out_ready);
    rel0 = (q0.size() > 0) && out_ready;
    @(posedge clk);
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (rel1) void'(q1.pop_front());
      if (acc1) q1.push_back({in_ctrl, in_data});
      if (rel0) void'(q0.pop_front());
      if (acc0) q0.push_back({in_ctrl, in_data});
    end
    if (q1.size() > 0) last1 = q1[0];
    if (q0.size() > 0) last0 = q0[0];
    #1;
  endtask

  task automatic model_clear();
    q1.delete(); q0.delete();
    last1 = '0; last0 = '0;
  endtask

  task automatic settle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, '0, '0);
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    total += 6;
    if (out_valid1 !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%b exp=0", out_valid1); end
    if (out_data1 !== '0)    begin bad++; $display("FAIL reset_data1 got=%h exp=0", out_data1); end
    if (out_ctrl1 !== '0)    begin bad++; $display("FAIL reset_ctrl1 got=%h exp=0", out_ctrl1); end
    if (occ1 !== 2'd0)       begin bad++; $display("FAIL reset_occ1 got=%0d exp=0", occ1); end
    if (out_valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid0 got=%b exp=0", out_valid0); end
    if (occ0 !== 2'd0)       begin bad++; $display("FAIL reset_occ0 got=%0d exp=0", occ0); end
    @(posedge clk); #3;
    reset = 1'b0;
    model_clear();
    #1;
    total += 2;
    if (in_ready1 !== 1'b1) begin bad++; $display("FAIL reset_ready1 got=%b exp=1", in_ready1); end
    if (in_ready0 !== 1'b1) begin bad++; $display("FAIL reset_ready0 got=%b exp=1", in_ready0); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] d[8];
    logic [CW-1:0] c[8];
    for (int i = 0; i < 8; i++) begin
      d[i] = $urandom();
      c[i] = CW'($urandom());
      drive(1'b0, 1'b1, 1'b1, d[i], c[i]);
      tick();
      total += 5;
      if (out_valid1 !== 1'b1) begin bad++; $display("FAIL stream_valid1[%0d] got=%b exp=1", i, out_valid1); end
      if (out_data1 !== d[i])  begin bad++; $display("FAIL stream_data1[%0d] got=%h exp=%h", i, out_data1, d[i]); end
      if (out_ctrl1 !== c[i])  begin bad++; $display("FAIL stream_ctrl1[%0d] got=%h exp=%h", i, out_ctrl1, c[i]); end
      if (occ1 !== 2'd1)       begin bad++; $display("FAIL stream_occ1[%0d] got=%0d exp=1", i, occ1); end
      if (out_data0 !== d[i])  begin bad++; $display("FAIL stream_data0[%0d] got=%h exp=%h", i, out_data0, d[i]); end
    end
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    total += 2;
    if (out_valid1 !== 1'b0) begin bad++; $display("FAIL stream_end_valid1 got=%b exp=0", out_valid1); end
    if (occ0 !== 2'd0)       begin bad++; $display("FAIL stream_end_occ0 got=%0d exp=0", occ0); end
  endtask

  task automatic test_skid_fill();
    logic [DW-1:0] a, b, cc;
    a = $urandom(); b = $urandom(); cc = $urandom();
    drive(1'b0, 1'b1, 1'b0, a, 8'h11);
    tick();
    drive(1'b0, 1'b1, 1'b0, b, 8'h22);
    total++;
    if (in_ready1 !== 1'b1) begin bad++; $display("FAIL skid_ready_one got=%b exp=1", in_ready1); end
    tick();
    total += 3;
    if (occ1 !== 2'd2)      begin bad++; $display("FAIL skid_occ_two got=%0d exp=2", occ1); end
    if (in_ready1 !== 1'b0) begin bad++; $display("FAIL skid_ready_two got=%b exp=0", in_ready1); end
    if (out_data1 !== a)    begin bad++; $display("FAIL skid_head_a got=%h exp=%h", out_data1, a); end
    // A third entry offered while full must be refused.
    drive(1'b0, 1'b1, 1'b0, cc, 8'h33);
    tick();
    total += 2;
    if (occ1 !== 2'd2)      begin bad++; $display("FAIL skid_hold_occ got=%0d exp=2", occ1); end
    if (out_ctrl1 !== 8'h11) begin bad++; $display("FAIL skid_hold_ctrl got=%h exp=11", out_ctrl1); end
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    total += 4;
    if (occ1 !== 2'd1)       begin bad++; $display("FAIL skid_drain_occ got=%0d exp=1", occ1); end
    if (out_data1 !== b)     begin bad++; $display("FAIL skid_head_b got=%h exp=%h", out_data1, b); end
    if (out_ctrl1 !== 8'h22) begin bad++; $display("FAIL skid_ctrl_b got=%h exp=22", out_ctrl1); end
    if (in_ready1 !== 1'b1)  begin bad++; $display("FAIL skid_ready_back got=%b exp=1", in_ready1); end
    tick();
    total++;
    if (out_valid1 !== 1'b0) begin bad++; $display("FAIL skid_empty got=%b exp=0", out_valid1); end
    settle();
  endtask

  task automatic test_flush();
    logic [DW-1:0] a, b, x;
    a = $urandom(); b = $urandom(); x = $urandom();
    drive(1'b0, 1'b1, 1'b0, a, 8'h41);
    tick();
    drive(1'b0, 1'b1, 1'b0, b, 8'h42);
    tick();
    drive(1'b1, 1'b1, 1'b0, x, 8'hFF);
    tick();
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    total += 7;
    if (out_valid1 !== 1'b0) begin bad++; $display("FAIL flush_valid1 got=%b exp=0", out_valid1); end
    if (out_ctrl1 !== 8'h00) begin bad++; $display("FAIL flush_ctrl1 got=%h exp=00", out_ctrl1); end
    if (occ1 !== 2'd0)       begin bad++; $display("FAIL flush_occ1 got=%0d exp=0", occ1); end
    if (in_ready1 !== 1'b1)  begin bad++; $display("FAIL flush_ready1 got=%b exp=1", in_ready1); end
    if (out_data1 !== a)     begin bad++; $display("FAIL flush_keep_data1 got=%h exp=%h", out_data1, a); end
    if (occ0 !== 2'd0)       begin bad++; $display("FAIL flush_occ0 got=%0d exp=0", occ0); end
    if (out_data0 !== a)     begin bad++; $display("FAIL flush_keep_data0 got=%h exp=%h", out_data0, a); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid1 !== 1'b0 || out_data1 === x) begin
        bad++; $display("FAIL flush_ghost[%0d] valid=%b data=%h exp valid=0", i, out_valid1, out_data1);
      end
    end
  endtask

  task automatic test_idle_ctrl();
    logic [DW-1:0] d;
    d = $urandom();
    drive(1'b0, 1'b1, 1'b1, d, 8'h03);
    tick();
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    total += 4;
    if (out_valid1 !== 1'b0) begin bad++; $display("FAIL idle_valid1 got=%b exp=0", out_valid1); end
    if (out_ctrl1 !== 8'h00) begin bad++; $display("FAIL idle_ctrl1 got=%h exp=00", out_ctrl1); end
    if (out_ctrl0 !== 8'h00) begin bad++; $display("FAIL idle_ctrl0 got=%h exp=00", out_ctrl0); end
    if (out_data1 !== d)     begin bad++; $display("FAIL idle_data1 got=%h exp=%h", out_data1, d); end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] e;
    e = $urandom();
    drive(1'b0, 1'b1, 1'b0, $urandom(), 8'h51);
    tick();
    drive(1'b0, 1'b1, 1'b0, $urandom(), 8'h52);
    tick();
    reset = 1'b1;
    #1;
    total += 4;
    if (out_valid1 !== 1'b0) begin bad++; $display("FAIL areset_valid1 got=%b exp=0", out_valid1); end
    if (out_data1 !== '0)    begin bad++; $display("FAIL areset_data1 got=%h exp=0", out_data1); end
    if (occ1 !== 2'd0)       begin bad++; $display("FAIL areset_occ1 got=%0d exp=0", occ1); end
    if (out_data0 !== '0)    begin bad++; $display("FAIL areset_data0 got=%h exp=0", out_data0); end
    @(posedge clk); #3;
    reset = 1'b0;
    model_clear();
    drive(1'b0, 1'b1, 1'b1, e, 8'h5A);
    total++;
    if (in_ready1 !== 1'b1) begin bad++; $display("FAIL areset_ready1 got=%b exp=1", in_ready1); end
    tick();
    total += 3;
    if (out_valid1 !== 1'b1) begin bad++; $display("FAIL areset_first_valid got=%b exp=1", out_valid1); end
    if (out_data1 !== e)     begin bad++; $display("FAIL areset_first_data1 got=%h exp=%h", out_data1, e); end
    if (out_data0 !== e)     begin bad++; $display("FAIL areset_first_data0 got=%h exp=%h", out_data0, e); end
    settle();
  endtask

  task automatic test_random();
    logic          er1, er0, ev1, ev0;
    logic [DW-1:0] ed1, ed0;
    logic [CW-1:0] ec1, ec0;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(15) == 0), $urandom_range(1), ($urandom_range(3) != 0),
            $urandom(), CW'($urandom()));
      er1 = (q1.size() < 2);
      er0 = (q0.size() == 0) || out_ready;
      total += 2;
      if (in_ready1 !== er1) begin bad++; $display("FAIL rnd_ready1[%0d] got=%b exp=%b", n, in_ready1, er1); end
      if (in_ready0 !== er0) begin bad++; $display("FAIL rnd_ready0[%0d] got=%b exp=%b", n, in_ready0, er0); end
      tick();
      ev1 = (q1.size() > 0);
      ev0 = (q0.size() > 0);
      ed1 = last1[DW-1:0];
      ed0 = last0[DW-1:0];
      ec1 = ev1 ? last1[DW +: CW] : '0;
      ec0 = ev0 ? last0[DW +: CW] : '0;
      total += 8;
      if (out_valid1 !== ev1) begin bad++; $display("FAIL rnd_valid1[%0d] got=%b exp=%b", n, out_valid1, ev1); end
      if (out_data1 !== ed1)  begin bad++; $display("FAIL rnd_data1[%0d] got=%h exp=%h", n, out_data1, ed1); end
      if (out_ctrl1 !== ec1)  begin bad++; $display("FAIL rnd_ctrl1[%0d] got=%h exp=%h", n, out_ctrl1, ec1); end
      if (occ1 !== 2'(q1.size())) begin bad++; $display("FAIL rnd_occ1[%0d] got=%0d exp=%0d", n, occ1, q1.size()); end
      if (out_valid0 !== ev0) begin bad++; $display("FAIL rnd_valid0[%0d] got=%b exp=%b", n, out_valid0, ev0); end
      if (out_data0 !== ed0)  begin bad++; $display("FAIL rnd_data0[%0d] got=%h exp=%h", n, out_data0, ed0); end
      if (out_ctrl0 !== ec0)  begin bad++; $display("FAIL rnd_ctrl0[%0d] got=%h exp=%h", n, out_ctrl0, ec0); end
      if (occ0 !== 2'(q0.size())) begin bad++; $display("FAIL rnd_occ0[%0d] got=%0d exp=%0d", n, occ0, q0.size()); end
    end
    settle();
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    #1;
    @(posedge clk); #2;
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
    end
    total += 2;
    if (bubble1 !== 16'd3) begin bad++; $display("FAIL perf_bubble_idle1 got=%0d exp=3", bubble1); end
    if (bubble0 !== 16'd3) begin bad++; $display("FAIL perf_bubble_idle0 got=%0d exp=3", bubble0); end
    drive(1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 8'h01);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 70000; i++) tick();
    total += 4;
    if (stall1 !== 16'hFFFF)  begin bad++; $display("FAIL perf_stall_sat1 got=%h exp=ffff", stall1); end
    if (stall0 !== 16'hFFFF)  begin bad++; $display("FAIL perf_stall_sat0 got=%h exp=ffff", stall0); end
    if (bubble1 !== 16'd4)    begin bad++; $display("FAIL perf_bubble_hold1 got=%0d exp=4", bubble1); end
    if (bubble0 !== 16'd4)    begin bad++; $display("FAIL perf_bubble_hold0 got=%0d exp=4", bubble0); end
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    total += 3;
    if (stall1 !== 16'hFFFF)  begin bad++; $display("FAIL perf_stall_flush1 got=%h exp=ffff", stall1); end
    if (bubble1 !== 16'd4)    begin bad++; $display("FAIL perf_bubble_flush1 got=%0d exp=4", bubble1); end
    if (out_valid1 !== 1'b0)  begin bad++; $display("FAIL perf_flush_valid1 got=%b exp=0", out_valid1); end
    tick();
    total += 2;
    if (bubble1 !== 16'd5)    begin bad++; $display("FAIL perf_bubble_after1 got=%0d exp=5", bubble1); end
    if (stall0 !== 16'hFFFF)  begin bad++; $display("FAIL perf_stall_after0 got=%h exp=ffff", stall0); end
  endtask
`endif

  initial begin
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_ctrl = '0;
    last1 = '0; last0 = '0;
    test_reset();
    test_stream();
    test_skid_fill();
    test_flush();
    test_idle_ctrl();
    test_async_reset();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
